axis_wrr_mux: RTL and testbench
===============================

# axis_wrr_mux

Packet-level N:1 AXI-Stream arbiter multiplexer with runtime-programmable weighted round-robin arbitration and a registered, full-throughput output stage. It is the parametrised successor to the fixed 4x1 round-robin switch configuration. It adds per-input packet weights, input disable via zero weight, and a source-index sideband. It sits in front of shared single-port consumers: DMA engines, MAC TX, and aggregation links.

## Interface
Parameters:
- S_COUNT, 4, number of input streams (≥2)
- DATA_WIDTH, 8, tdata width
- KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep (tied all-ones when 0)
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ID_ENABLE / ID_WIDTH, 1 / 8, carry tid (zero when disabled)
- DEST_WIDTH, 8, tdest width, passed through
- USER_ENABLE / USER_WIDTH, 1 / 1, carry tuser (zero when disabled)
- WEIGHT_WIDTH, 4, bits per input weight
- SRC_WIDTH, $clog2(S_COUNT), source-index width

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  S_COUNT×field  packed input streams, input 0 in LSBs
- cfg_weight  in  S_COUNT*WEIGHT_WIDTH  packets per turn per input; 0 = input disabled
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  1×field  output stream
- m_axis_tsrc  out  SRC_WIDTH  index of the input that produced the current output beat

## Operation
- State machine: IDLE, ACTIVE.
- IDLE: an input is eligible when its tvalid is 1 and its weight is nonzero. If any input is eligible, the arbiter registers a grant g and moves to ACTIVE.
- ACTIVE: only s_axis_tready[g] may be 1, and it equals the output stage's ready. A beat with tlast=1 that is accepted from g returns the machine to IDLE.
- Packets are never interleaved.
- Grant selection, evaluated in IDLE:
  - If the last grant g still has tvalid=1 and credit c>0, g is granted again and c decrements.
  - Otherwise the winner is the first eligible input scanning g+1, g+2, … modulo S_COUNT. In that case c loads weight[winner]−1.
- Weights are sampled only at grant time. A change while ACTIVE applies at the next arbitration.
- Weight 0: the input's tready stays 0 permanently.
- Output register is a 2-entry skid buffer (main + temp).
  - Its ready to the input side is !temp_full, registered.
  - It sustains 1 beat/cycle under continuous m_axis_tready.
  - It never drops or duplicates a beat under arbitrary m_axis_tready toggling.
- m_axis_tsrc travels with each beat through the skid buffer.
- tdest, tid, tuser, tkeep and tlast are passed through unchanged.

## Timing
- Reset values:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - m_axis data, sideband fields and m_axis_tsrc=0.
  - State IDLE, g=S_COUNT−1 (so the first scan starts at input 0), c=0.
- Arbitration: 1 cycle in IDLE. s_axis_tready[g] rises the cycle after tvalid is first seen. There is exactly 1 idle bubble between consecutive packets.
- Latency: a beat accepted at cycle n appears on m_axis at cycle n+1.
- tvalid=1 with tready=0 at a source must hold data stable (AXI rule). The block's behaviour is undefined otherwise.
- rst asserted mid-packet:
  - Next cycle, all state returns to reset values and any buffered beats are discarded.
  - The partial packet is not completed. Upstream is responsible for resync.
- tlast accepted in the same cycle as another input's tvalid rising: the new input is considered at the next IDLE cycle.
- All weights 0: the machine stays IDLE with all tready 0.

## Structure
- Shared package axis_wrr_pkg:
  - state enum {IDLE, ACTIVE}
  - round-robin priority-scan function (rotate, LSB find-first, unrotate)
- Sub-module axis_wrr_arbiter:
  - holds the grant, credit counter and state machine
  - inputs: eligible vector, weights, packet-done pulse
  - outputs: grant index, grant valid
- The top level holds the data mux and the skid-buffer output register.

## Test plan
- Single packet, 3 beats (0xA1, 0xA2, 0xA3) on input 2, m_tready=1:
  - tready[2] high at cycle 1, beats appear cycles 2–4
  - m_axis_tsrc=2, tlast on 0xA3
- All 4 inputs continuously valid, 1-beat packets, weights {1,1,1,1} → tsrc order 0,1,2,3,0,1…, one bubble between packets.
- Weights w0=3, w1=1, w2=w3=0, inputs 0 and 1 continuously valid:
  - tsrc pattern 0,0,0,1,0,0,0,1
  - tready[2] and tready[3] never assert
- 8-beat packets on inputs 0 and 1, m_axis_tready random at 50%:
  - scoreboard shows all beats in order, no loss or duplication, no interleaving
  - tid/tdest/tuser match the source
- cfg_weight[0] changed 1→4 while input 0 is mid-packet:
  - the current turn is unaffected
  - the next grant of input 0 allows 4 consecutive packets
- rst pulsed for 1 cycle during beat 3 of an 8-beat packet:
  - next cycle m_axis_tvalid=0 and all tready=0
  - after release, the first grant goes to the lowest eligible input

Source files
------------

// File: rtl/axis_wrr_pkg.sv
// Shared types and the round-robin priority scan used by the weighted
// round-robin AXI-Stream multiplexer.
package axis_wrr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int RR_MAX_PORTS = 32;

  // Rotate the request vector so 'start' sits at bit 0, find the lowest set
  // bit, then map it back to an absolute index. Returns -1 when nothing is set.
  function automatic int rr_scan(input logic [RR_MAX_PORTS-1:0] req,
                                 input int ports,
                                 input int start);
    logic [RR_MAX_PORTS-1:0] rot;
    int k;
    int pick;
    rot  = '0;
    pick = -1;
    k    = 0;
    for (int i = 0; i < RR_MAX_PORTS; i++) begin
      if (i < ports) begin
        k      = (start + i) % ports;
        rot[i] = req[k];
      end
    end
    for (int i = RR_MAX_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick = (start + i) % ports;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter: holds the grant, the remaining
// packet credit of the granted input and the IDLE/ACTIVE state machine.
module axis_wrr_arbiter
  import axis_wrr_pkg::*;
#(
  parameter int S_COUNT      = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int SRC_WIDTH    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT-1:0]              eligible,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] weight,
  input  logic                            pkt_done,
  output logic [SRC_WIDTH-1:0]            grant,
  output logic                            grant_valid
);

  localparam logic [WEIGHT_WIDTH-1:0] CREDIT_ONE = WEIGHT_WIDTH'(1);

  arb_state_t                state;
  logic [WEIGHT_WIDTH-1:0]   credit;
  logic [RR_MAX_PORTS-1:0]   req;
  int                        start;
  int                        winner;
  logic [WEIGHT_WIDTH-1:0]   win_weight;
  logic                      regrant;

  // Next-winner search starting just after the last grant
  always_comb begin
    req                = '0;
    req[S_COUNT-1:0]   = eligible;
    start              = (int'(grant) + 1) % S_COUNT;
    winner             = rr_scan(req, S_COUNT, start);
    regrant            = eligible[grant] && (credit != '0);
    if (winner >= 0) begin
      win_weight = weight[winner*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end else begin
      win_weight = '0;
    end
  end

  // Grant/credit state machine; weights are only sampled when a grant is made
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= SRC_WIDTH'(S_COUNT - 1);
      credit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (regrant) begin
            state  <= ACTIVE;
            credit <= credit - CREDIT_ONE;
          end else if (winner >= 0) begin
            state  <= ACTIVE;
            grant  <= SRC_WIDTH'(winner);
            credit <= win_weight - CREDIT_ONE;
          end
        end
        ACTIVE: begin
          if (pkt_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_valid = (state == ACTIVE);

endmodule

// File: rtl/axis_wrr_mux.sv
// N:1 AXI-Stream packet multiplexer with weighted round-robin arbitration and
// a two-entry skid buffer on the output; the source index rides with each beat.
module axis_wrr_mux
  import axis_wrr_pkg::*;
#(
  parameter int S_COUNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = (DATA_WIDTH / 8),
  parameter int ID_ENABLE    = 1,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1,
  parameter int WEIGHT_WIDTH = 4,
  parameter int SRC_WIDTH    = $clog2(S_COUNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]     s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic [DEST_WIDTH-1:0]           m_axis_tdest,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic [SRC_WIDTH-1:0]            m_axis_tsrc
);

  localparam int BEAT_W = SRC_WIDTH + USER_WIDTH + DEST_WIDTH + ID_WIDTH + 1 +
                          KEEP_WIDTH + DATA_WIDTH;

  logic [S_COUNT-1:0]    eligible;
  logic [SRC_WIDTH-1:0]  grant;
  logic                  grant_valid;
  logic                  pkt_done;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  accept;
  logic [BEAT_W-1:0]     in_beat;

  logic                  skid_ready;
  logic                  ready_next;
  logic                  main_valid;
  logic [BEAT_W-1:0]     main_beat;
  logic                  temp_valid;
  logic [BEAT_W-1:0]     temp_beat;

  // A zero weight removes an input from arbitration entirely
  always_comb begin
    eligible = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      eligible[i] = s_axis_tvalid[i] && (cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  axis_wrr_arbiter #(
    .S_COUNT      (S_COUNT),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .SRC_WIDTH    (SRC_WIDTH)
  ) u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .eligible    (eligible),
    .weight      (cfg_weight),
    .pkt_done    (pkt_done),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Only the granted input sees the skid buffer's ready
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      s_axis_tready[i] = grant_valid && skid_ready && (grant == SRC_WIDTH'(i));
    end
  end

  // Data mux onto the granted input, with disabled sidebands forced to defaults
  always_comb begin
    sel_data  = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    sel_dest  = s_axis_tdest[int'(grant)*DEST_WIDTH +: DEST_WIDTH];
    sel_last  = s_axis_tlast[grant];
    sel_valid = grant_valid && s_axis_tvalid[grant];
    if (KEEP_ENABLE != 0) begin
      sel_keep = s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
    end else begin
      sel_keep = '1;
    end
    if (ID_ENABLE != 0) begin
      sel_id = s_axis_tid[int'(grant)*ID_WIDTH +: ID_WIDTH];
    end else begin
      sel_id = '0;
    end
    if (USER_ENABLE != 0) begin
      sel_user = s_axis_tuser[int'(grant)*USER_WIDTH +: USER_WIDTH];
    end else begin
      sel_user = '0;
    end
    accept   = sel_valid && skid_ready;
    pkt_done = accept && sel_last;
    in_beat  = {grant, sel_user, sel_dest, sel_id, sel_last, sel_keep, sel_data};
  end

  // Ready drops only on the cycle the temp slot fills, so it tracks !temp_valid
  always_comb begin
    ready_next = m_axis_tready || (!temp_valid && (!main_valid || !accept));
  end

  // Skid buffer: main register drives m_axis, temp catches the beat in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ready <= 1'b0;
      main_valid <= 1'b0;
      main_beat  <= '0;
      temp_valid <= 1'b0;
      temp_beat  <= '0;
    end else begin
      skid_ready <= ready_next;
      if (skid_ready) begin
        if (m_axis_tready || !main_valid) begin
          main_valid <= accept;
          if (accept) begin
            main_beat <= in_beat;
          end
        end else begin
          temp_valid <= accept;
          if (accept) begin
            temp_beat <= in_beat;
          end
        end
      end else if (m_axis_tready) begin
        main_valid <= temp_valid;
        main_beat  <= temp_beat;
        temp_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = main_valid;
  assign {m_axis_tsrc, m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tlast,
          m_axis_tkeep, m_axis_tdata} = main_beat;

endmodule

// File: tb/tb_axis_wrr_mux.sv
// Self-checking bench for axis_wrr_mux: random packet traffic scored against a
// packet-level weighted round-robin reference model.
module tb_axis_wrr_mux;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 8;
  localparam int DSW = 8;
  localparam int UW = 1;
  localparam int WW = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [S*DW-1:0] s_tdata;
  logic [S*KW-1:0] s_tkeep;
  logic [S-1:0]    s_tvalid;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_tlast;
  logic [S*IW-1:0] s_tid;
  logic [S*DSW-1:0] s_tdest;
  logic [S*UW-1:0] s_tuser;
  logic [S*WW-1:0] cfg_weight;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic [DSW-1:0]  m_tdest;
  logic [UW-1:0]   m_tuser;
  logic [SW-1:0]   m_tsrc;

  always #5 clk = ~clk;

  axis_wrr_mux dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tid    (s_tid),
    .s_axis_tdest  (s_tdest),
    .s_axis_tuser  (s_tuser),
    .cfg_weight    (cfg_weight),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tdest  (m_tdest),
    .m_axis_tuser  (m_tuser),
    .m_axis_tsrc   (m_tsrc)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] id;
    logic [7:0] dest;
    logic       user;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [1:0] src;
  } exp_t;

  beat_t src_q[4][$];
  exp_t  exp_q[$];
  int    out_cyc_q[$];
  int    first_rdy[4];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic drive_inputs();
    beat_t b;
    for (int i = 0; i < S; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tvalid[i]        = 1'b1;
        s_tdata[i*8 +: 8]  = b.data;
        s_tlast[i]         = b.last;
        s_tid[i*8 +: 8]    = b.id;
        s_tdest[i*8 +: 8]  = b.dest;
        s_tuser[i]         = b.user;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  endtask

  task automatic gen_pkts(input int src, input int npk, input int len);
    beat_t b;
    for (int p = 0; p < npk; p++) begin
      b.id   = 8'($urandom);
      b.dest = 8'($urandom);
      b.user = 1'($urandom);
      for (int k = 0; k < len; k++) begin
        b.data = 8'($urandom);
        b.last = (k == len - 1);
        src_q[src].push_back(b);
      end
    end
  endtask

  // Packet-level reference: who gets each turn, given packets waiting per input
  task automatic build_expected(input logic [15:0] w_first, input logic [15:0] w_rest);
    int npk[4];
    int pos[4];
    int g;
    int c;
    int n;
    bit found;
    logic [15:0] w;
    logic [3:0] elig;
    beat_t b;
    exp_t e;
    for (int i = 0; i < S; i++) begin
      npk[i] = 0;
      pos[i] = 0;
      foreach (src_q[i][k]) if (src_q[i][k].last) npk[i]++;
    end
    g = 3;
    c = 0;
    n = 0;
    while (1) begin
      w = (n == 0) ? w_first : w_rest;
      for (int i = 0; i < S; i++) elig[i] = (npk[i] > 0) && (w[i*4 +: 4] != 4'd0);
      if (elig[g] && c > 0) begin
        c = c - 1;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= S; k++) begin
          if (!found && elig[(g + k) % S]) begin
            g = (g + k) % S;
            found = 1'b1;
          end
        end
        if (!found) break;
        c = int'(w[g*4 +: 4]) - 1;
      end
      do begin
        b = src_q[g][pos[g]];
        pos[g]++;
        e.b = b;
        e.src = 2'(g);
        exp_q.push_back(e);
      end while (!b.last);
      npk[g]--;
      n++;
    end
  endtask

  // Cycle engine: drives sources, randomises m_tready, scores every output beat
  task automatic engine(input int ready_pct, input int max_cyc, input int chg_cyc,
                        input logic [15:0] chg_w, input bit partial);
    int cyc;
    bit done;
    logic [3:0] acc;
    logic [3:0] zero_mask;
    exp_t e;
    for (int i = 0; i < S; i++) first_rdy[i] = -1;
    out_cyc_q.delete();
    @(posedge clk);
    #1;
    drive_inputs();
    m_tready = ($urandom_range(99) < ready_pct);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      for (int i = 0; i < S; i++) zero_mask[i] = (cfg_weight[i*4 +: 4] == 4'd0);
      n_checks++;
      if (!$onehot0(s_tready) || ((s_tready & zero_mask) != 4'd0)) begin
        n_fail++;
        $display("FAIL tready_legal cyc=%0d got tready=%b zero_weight_mask=%b", cyc, s_tready, zero_mask);
      end
      for (int i = 0; i < S; i++) begin
        acc[i] = s_tvalid[i] && s_tready[i];
        if (s_tready[i] && first_rdy[i] < 0) first_rdy[i] = cyc;
      end
      if (m_tvalid && m_tready) begin
        out_cyc_q.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat cyc=%0d got data=%h src=%0d, none expected", cyc, m_tdata, m_tsrc);
        end else begin
          e = exp_q.pop_front();
          if ({m_tdata, m_tlast, m_tid, m_tdest, m_tuser, m_tsrc, m_tkeep} !==
              {e.b.data, e.b.last, e.b.id, e.b.dest, e.b.user, e.src, 1'b1}) begin
            n_fail++;
            $display("FAIL beat cyc=%0d got d=%h l=%b id=%h de=%h u=%b src=%0d k=%b exp d=%h l=%b id=%h de=%h u=%b src=%0d k=1",
                     cyc, m_tdata, m_tlast, m_tid, m_tdest, m_tuser, m_tsrc, m_tkeep,
                     e.b.data, e.b.last, e.b.id, e.b.dest, e.b.user, e.src);
          end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < S; i++) if (acc[i]) void'(src_q[i].pop_front());
      if (cyc == chg_cyc) cfg_weight = chg_w;
      drive_inputs();
      m_tready = ($urandom_range(99) < ready_pct);
      if (!partial && exp_q.size() == 0) done = 1'b1;
    end
    if (!partial) begin
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL timeout got %0d beats outstanding, required 0", exp_q.size());
      end else begin
        m_tready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          n_checks++;
          if (m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done got m_tvalid=%b required 0", m_tvalid);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    for (int i = 0; i < S; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_tvalid = 4'hF;
    cfg_weight = 16'h1111;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b required 0", m_tvalid); end
    n_checks++;
    if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready got %b required 0000", s_tready); end
    n_checks++;
    if ({m_tdata, m_tlast, m_tid, m_tdest, m_tuser, m_tsrc} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_fields got d=%h l=%b id=%h de=%h u=%b src=%0d required all 0",
               m_tdata, m_tlast, m_tid, m_tdest, m_tuser, m_tsrc);
    end
    do_reset();
  endtask

  task automatic test_single_packet();
    beat_t b;
    do_reset();
    cfg_weight = 16'h1111;
    b.id = 8'h5C;
    b.dest = 8'h33;
    b.user = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b.data = 8'hA1 + 8'(k);
      b.last = (k == 2);
      src_q[2].push_back(b);
    end
    build_expected(16'h1111, 16'h1111);
    engine(100, 100, -1, 16'h0, 1'b0);
    n_checks++;
    if (first_rdy[2] != 1) begin n_fail++; $display("FAIL single_tready_cycle got %0d required 1", first_rdy[2]); end
    n_checks++;
    if (out_cyc_q.size() != 3 || out_cyc_q[0] != 2 || out_cyc_q[1] != 3 || out_cyc_q[2] != 4) begin
      n_fail++;
      $display("FAIL single_out_cycles got %p required '{2,3,4}", out_cyc_q);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cfg_weight = 16'h1111;
    for (int i = 0; i < S; i++) gen_pkts(i, 3, 1);
    build_expected(16'h1111, 16'h1111);
    engine(100, 200, -1, 16'h0, 1'b0);
    n_checks++;
    if (out_cyc_q.size() != 12) begin
      n_fail++;
      $display("FAIL rr_count got %0d beats required 12", out_cyc_q.size());
    end
    for (int k = 1; k < out_cyc_q.size(); k++) begin
      n_checks++;
      if (out_cyc_q[k] - out_cyc_q[k-1] != 2) begin
        n_fail++;
        $display("FAIL rr_bubble got gap %0d required 2 at beat %0d", out_cyc_q[k] - out_cyc_q[k-1], k);
      end
    end
  endtask

  task automatic test_weighted();
    do_reset();
    cfg_weight = 16'h0013;
    gen_pkts(0, 12, 1);
    gen_pkts(1, 4, 1);
    gen_pkts(2, 2, 1);
    gen_pkts(3, 2, 1);
    build_expected(16'h0013, 16'h0013);
    engine(100, 300, -1, 16'h0, 1'b0);
  endtask

  task automatic test_random_ready();
    do_reset();
    cfg_weight = 16'h1111;
    gen_pkts(0, 6, 8);
    gen_pkts(1, 6, 8);
    build_expected(16'h1111, 16'h1111);
    engine(50, 2000, -1, 16'h0, 1'b0);
  endtask

  task automatic test_weight_change();
    do_reset();
    cfg_weight = 16'h1111;
    gen_pkts(0, 6, 8);
    gen_pkts(1, 2, 8);
    build_expected(16'h1111, 16'h1114);
    engine(100, 1000, 3, 16'h1114, 1'b0);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    cfg_weight = 16'h1111;
    gen_pkts(0, 1, 8);
    build_expected(16'h1111, 16'h1111);
    engine(100, 3, -1, 16'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = '0;
    @(negedge clk);
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid got %b required 0", m_tvalid); end
    n_checks++;
    if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL midrst_tready got %b required 0000", s_tready); end
    for (int i = 0; i < S; i++) src_q[i].delete();
    exp_q.delete();
    gen_pkts(0, 1, 2);
    gen_pkts(2, 1, 2);
    build_expected(16'h1111, 16'h1111);
    engine(100, 200, -1, 16'h0, 1'b0);
    n_checks++;
    if (first_rdy[0] != 1) begin n_fail++; $display("FAIL midrst_first_grant got tready0 cycle %0d required 1", first_rdy[0]); end
  endtask

  task automatic test_all_zero();
    do_reset();
    cfg_weight = 16'h0000;
    for (int i = 0; i < S; i++) gen_pkts(i, 1, 2);
    build_expected(16'h0000, 16'h0000);
    engine(100, 20, -1, 16'h0, 1'b1);
    n_checks++;
    if (out_cyc_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL all_zero got %0d output beats required 0", out_cyc_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0;
    s_tkeep = '1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tid = '0;
    s_tdest = '0;
    s_tuser = '0;
    cfg_weight = '0;
    m_tready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_weighted();
    test_random_ready();
    test_weight_change();
    test_reset_mid_packet();
    test_all_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
